commit_queue: RTL and testbench

- Parametrised in-order retire buffer between the mem stage and ctrl/regfile/csr; successor to the fixed dual-lane mem->wb->ctrl commit path.
- Accepts up to ISSUE_WIDTH completed instructions per cycle and retires up to RETIRE_WIDTH per cycle in program order.
- Enforces one CSR write per cycle, precise exceptions and younger-entry squash.
- Decouples mem-stage completion from commit.

---
 rtl/commit_queue_pkg.sv | 25 ++
 rtl/commit_queue_if.sv | 64 ++++++
 rtl/commit_queue_select.sv | 56 +++++
 rtl/commit_queue.sv | 179 +++++++++++++++++
 tb/tb_commit_queue.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_queue_pkg.sv
// commit_queue_pkg: shared types and default sizes for the in-order commit queue.
//   commit_entry_t : one completed instruction waiting to retire
//   COMMIT_DEPTH / RETIRE_WIDTH / ISSUE_WIDTH / REG_ADDR_W : default geometry
package commit_queue_pkg;

    localparam int COMMIT_DEPTH = 8;
    localparam int RETIRE_WIDTH = 2;
    localparam int ISSUE_WIDTH  = 2;
    localparam int REG_ADDR_W   = 5;
    localparam int CSR_ADDR_W   = 14;
    localparam int EXCP_CODE_W  = 7;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    reg_we;
        logic [REG_ADDR_W-1:0]   reg_addr;
        logic [31:0]             reg_data;
        logic                    csr_we;
        logic [CSR_ADDR_W-1:0]   csr_addr;
        logic [31:0]             csr_data;
        logic                    excp;
        logic [EXCP_CODE_W-1:0]  excp_code;
    } commit_entry_t;

endpackage

// File: rtl/commit_queue_if.sv
// commit_queue_if: enqueue side (from mem stage) and retire side (to regfile/csr)
// of the commit queue, plus flush/pause controls.
//   master : producer/consumer view (drives in_*, flush, retire_pause)
//   slave  : the queue itself
// Optional macro COMMIT_TRACE_EN adds trace_pc and retired_cnt.
interface commit_queue_if
    import commit_queue_pkg::*;
#(
    parameter int ISSUE_WIDTH  = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 4
);
    logic                                       flush;
    logic                                       retire_pause;
    logic [ISSUE_WIDTH-1:0]                     in_valid;
    logic [ISSUE_WIDTH-1:0][31:0]               in_pc;
    logic [ISSUE_WIDTH-1:0]                     in_reg_we;
    logic [ISSUE_WIDTH-1:0][REG_ADDR_W-1:0]     in_reg_addr;
    logic [ISSUE_WIDTH-1:0][31:0]               in_reg_data;
    logic [ISSUE_WIDTH-1:0]                     in_csr_we;
    logic [ISSUE_WIDTH-1:0][CSR_ADDR_W-1:0]     in_csr_addr;
    logic [ISSUE_WIDTH-1:0][31:0]               in_csr_data;
    logic [ISSUE_WIDTH-1:0]                     in_excp;
    logic [ISSUE_WIDTH-1:0][EXCP_CODE_W-1:0]    in_excp_code;
    logic                                       in_ready;

    logic [RETIRE_WIDTH-1:0]                    out_valid;
    logic [RETIRE_WIDTH-1:0]                    out_reg_we;
    logic [RETIRE_WIDTH-1:0][REG_ADDR_W-1:0]    out_reg_addr;
    logic [RETIRE_WIDTH-1:0][31:0]              out_reg_data;
    logic                                       out_csr_we;
    logic [CSR_ADDR_W-1:0]                      out_csr_addr;
    logic [31:0]                                out_csr_data;
    logic                                       excp_valid;
    logic [31:0]                                excp_pc;
    logic [EXCP_CODE_W-1:0]                     excp_code;
    logic [CNT_W-1:0]                           count;
`ifdef COMMIT_TRACE_EN
    logic [RETIRE_WIDTH-1:0][31:0]              trace_pc;
    logic [63:0]                                retired_cnt;
`endif

    modport master (
        output flush, retire_pause, in_valid, in_pc, in_reg_we, in_reg_addr, in_reg_data,
               in_csr_we, in_csr_addr, in_csr_data, in_excp, in_excp_code,
        input  in_ready, out_valid, out_reg_we, out_reg_addr, out_reg_data,
               out_csr_we, out_csr_addr, out_csr_data, excp_valid, excp_pc, excp_code, count
`ifdef COMMIT_TRACE_EN
        , input trace_pc, retired_cnt
`endif
    );

    modport slave (
        input  flush, retire_pause, in_valid, in_pc, in_reg_we, in_reg_addr, in_reg_data,
               in_csr_we, in_csr_addr, in_csr_data, in_excp, in_excp_code,
        output in_ready, out_valid, out_reg_we, out_reg_addr, out_reg_data,
               out_csr_we, out_csr_addr, out_csr_data, excp_valid, excp_pc, excp_code, count
`ifdef COMMIT_TRACE_EN
        , output trace_pc, retired_cnt
`endif
    );

endinterface

// File: rtl/commit_queue_select.sv
// commit_queue_select: combinational scan of the oldest RETIRE_WIDTH entries.
//   i_count/i_pause     : occupancy and retire hold
//   i_csr_we/i_excp     : per-slot flags, slot 0 = oldest
//   o_k                 : number of entries retiring this cycle
//   o_csr_hit/o_csr_lane: the single CSR write allowed this cycle
//   o_excp_hit/lane     : exception retiring this cycle (only ever from slot 0)
module commit_queue_select #(
    parameter int RETIRE_WIDTH = 2,
    parameter int CNT_W        = 4,
    parameter int K_W          = 2,
    parameter int LANE_W       = 1
) (
    input  logic [CNT_W-1:0]        i_count,
    input  logic                    i_pause,
    input  logic [RETIRE_WIDTH-1:0] i_csr_we,
    input  logic [RETIRE_WIDTH-1:0] i_excp,
    output logic [K_W-1:0]          o_k,
    output logic                    o_csr_hit,
    output logic [LANE_W-1:0]       o_csr_lane,
    output logic                    o_excp_hit,
    output logic [LANE_W-1:0]       o_excp_lane
);
    logic w_stop;

    always_comb begin
        o_k         = '0;
        o_csr_hit   = 1'b0;
        o_csr_lane  = '0;
        o_excp_hit  = 1'b0;
        o_excp_lane = '0;
        w_stop      = 1'b0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (!w_stop && !i_pause && (CNT_W'(i) < i_count)) begin
                if (i_excp[i]) begin
                    // An exception only retires once it is the oldest entry, so
                    // everything older has already committed when it is reported.
                    if (i == 0) begin
                        o_k         = K_W'(1);
                        o_excp_hit  = 1'b1;
                        o_excp_lane = LANE_W'(i);
                    end
                    w_stop = 1'b1;
                end else if (i_csr_we[i] && o_csr_hit) begin
                    w_stop = 1'b1;
                end else begin
                    o_k = K_W'(i + 1);
                    if (i_csr_we[i]) begin
                        o_csr_hit  = 1'b1;
                        o_csr_lane = LANE_W'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_queue.sv
// commit_queue: in-order retire buffer between mem stage and regfile/csr.
//   clk, rst : clock, synchronous active-high reset
//   bus      : commit_queue_if.slave (enqueue lanes, retire lanes, CSR port,
//              exception report, flush, retire_pause, count, in_ready)
// Optional macro COMMIT_TRACE_EN: adds trace_pc and retired_cnt outputs.
module commit_queue #(
    parameter int ISSUE_WIDTH  = commit_queue_pkg::ISSUE_WIDTH,
    parameter int RETIRE_WIDTH = commit_queue_pkg::RETIRE_WIDTH,
    parameter int DEPTH        = commit_queue_pkg::COMMIT_DEPTH,
    parameter int REG_ADDR_W   = commit_queue_pkg::REG_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    commit_queue_if.slave bus
);
    import commit_queue_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int K_W    = $clog2(RETIRE_WIDTH + 1);
    localparam int LANE_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;

    commit_entry_t                          r_mem [DEPTH];
    logic [PTR_W-1:0]                       r_head, r_tail;
    logic [RETIRE_WIDTH-1:0]                r_out_valid, r_out_reg_we;
    logic [RETIRE_WIDTH-1:0][REG_ADDR_W-1:0] r_out_reg_addr;
    logic [RETIRE_WIDTH-1:0][31:0]          r_out_reg_data;
    logic                                   r_out_csr_we, r_excp_valid;
    logic [CSR_ADDR_W-1:0]                  r_out_csr_addr;
    logic [31:0]                            r_out_csr_data, r_excp_pc;
    logic [EXCP_CODE_W-1:0]                 r_excp_code;

    logic [PTR_W-1:0]                       w_count, w_n_enq;
    logic                                   w_ready, w_enq;
    commit_entry_t                          w_slot [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0]                w_slot_csr, w_slot_excp;
    logic [K_W-1:0]                         w_k;
    logic                                   w_csr_hit, w_excp_hit;
    logic [LANE_W-1:0]                      w_csr_lane, w_excp_lane;
    logic [RETIRE_WIDTH-1:0]                w_valid, w_reg_we;
    logic [RETIRE_WIDTH-1:0][REG_ADDR_W-1:0] w_reg_addr;
    logic [RETIRE_WIDTH-1:0][31:0]          w_reg_data, w_pc;

    assign w_count = r_tail - r_head;
    // Ready looks only at pre-retire occupancy, so a full queue never admits
    // even when the same cycle frees slots.
    assign w_ready = !rst && ((PTR_W'(DEPTH) - w_count) >= PTR_W'(ISSUE_WIDTH));
    assign w_enq   = w_ready && bus.in_valid[0];

    always_comb begin
        w_n_enq = '0;
        for (int l = 0; l < ISSUE_WIDTH; l++) w_n_enq = w_n_enq + PTR_W'(bus.in_valid[l]);
    end

    always_comb begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            w_slot[i]      = r_mem[IDX_W'(r_head + PTR_W'(i))];
            w_slot_csr[i]  = w_slot[i].csr_we;
            w_slot_excp[i] = w_slot[i].excp;
        end
    end

    commit_queue_select #(
        .RETIRE_WIDTH(RETIRE_WIDTH), .CNT_W(PTR_W), .K_W(K_W), .LANE_W(LANE_W)
    ) u_select (
        .i_count(w_count), .i_pause(bus.retire_pause),
        .i_csr_we(w_slot_csr), .i_excp(w_slot_excp),
        .o_k(w_k), .o_csr_hit(w_csr_hit), .o_csr_lane(w_csr_lane),
        .o_excp_hit(w_excp_hit), .o_excp_lane(w_excp_lane)
    );

    always_comb begin
        w_valid    = '0;
        w_reg_we   = '0;
        w_reg_addr = '0;
        w_reg_data = '0;
        w_pc       = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (K_W'(i) < w_k) begin
                w_valid[i]    = 1'b1;
                w_reg_we[i]   = w_slot[i].reg_we && !w_slot[i].excp && (w_slot[i].reg_addr != '0);
                w_reg_addr[i] = w_slot[i].reg_addr;
                w_reg_data[i] = w_slot[i].reg_data;
                w_pc[i]       = w_slot[i].pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (bus.in_valid[l]) begin
                    r_mem[IDX_W'(r_tail + PTR_W'(l))] <= '{
                        pc: bus.in_pc[l], reg_we: bus.in_reg_we[l],
                        reg_addr: bus.in_reg_addr[l], reg_data: bus.in_reg_data[l],
                        csr_we: bus.in_csr_we[l], csr_addr: bus.in_csr_addr[l],
                        csr_data: bus.in_csr_data[l], excp: bus.in_excp[l],
                        excp_code: bus.in_excp_code[l]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_out_valid    <= '0;
            r_out_reg_we   <= '0;
            r_out_reg_addr <= '0;
            r_out_reg_data <= '0;
            r_out_csr_we   <= 1'b0;
            r_out_csr_addr <= '0;
            r_out_csr_data <= '0;
            r_excp_valid   <= 1'b0;
            r_excp_pc      <= '0;
            r_excp_code    <= '0;
        end else begin
            r_out_valid    <= w_valid;
            r_out_reg_we   <= w_reg_we;
            r_out_reg_addr <= w_reg_addr;
            r_out_reg_data <= w_reg_data;
            r_out_csr_we   <= w_csr_hit;
            r_out_csr_addr <= w_csr_hit ? w_slot[w_csr_lane].csr_addr : '0;
            r_out_csr_data <= w_csr_hit ? w_slot[w_csr_lane].csr_data : '0;
            r_excp_valid   <= w_excp_hit;
            r_excp_pc      <= w_excp_hit ? w_slot[w_excp_lane].pc : '0;
            r_excp_code    <= w_excp_hit ? w_slot[w_excp_lane].excp_code : '0;
            if (w_excp_hit) begin
                // Precise exception: every younger entry and this cycle's enqueue is squashed.
                r_head <= '0;
                r_tail <= '0;
            end else begin
                r_head <= r_head + PTR_W'(w_k);
                if (w_enq) r_tail <= r_tail + w_n_enq;
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.count        = w_count;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_reg_we   = r_out_reg_we;
    assign bus.out_reg_addr = r_out_reg_addr;
    assign bus.out_reg_data = r_out_reg_data;
    assign bus.out_csr_we   = r_out_csr_we;
    assign bus.out_csr_addr = r_out_csr_addr;
    assign bus.out_csr_data = r_out_csr_data;
    assign bus.excp_valid   = r_excp_valid;
    assign bus.excp_pc      = r_excp_pc;
    assign bus.excp_code    = r_excp_code;

`ifdef COMMIT_TRACE_EN
    logic [RETIRE_WIDTH-1:0][31:0] r_trace_pc;
    logic [63:0]                   r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) r_trace_pc <= '0;
        else                  r_trace_pc <= w_pc;
    end

    // Survives flush on purpose: it is a lifetime statistic, not queue state.
    always_ff @(posedge clk) begin
        if (rst)             r_retired_cnt <= '0;
        else if (!bus.flush) r_retired_cnt <= r_retired_cnt + 64'(w_k) - 64'(w_excp_hit);
    end

    assign bus.trace_pc    = r_trace_pc;
    assign bus.retired_cnt = r_retired_cnt;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^w_pc;
`endif

    // Enqueue lanes must be packed low: 00, 01, 11, 0111...
    a_in_valid_packed: assert property (@(posedge clk) disable iff (rst)
        ((bus.in_valid & (bus.in_valid + ISSUE_WIDTH'(1))) == '0));

endmodule

// File: tb/tb_commit_queue.sv
module tb_commit_queue;
    import commit_queue_pkg::*;

    localparam int IW = 2;
    localparam int RW = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    commit_queue_if #(.ISSUE_WIDTH(IW), .RETIRE_WIDTH(RW), .REG_ADDR_W(5), .CNT_W(4)) bus();

    commit_queue #(.ISSUE_WIDTH(IW), .RETIRE_WIDTH(RW), .DEPTH(DEPTH), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        bus.in_valid = '0; bus.in_pc = '0; bus.in_reg_we = '0; bus.in_reg_addr = '0;
        bus.in_reg_data = '0; bus.in_csr_we = '0; bus.in_csr_addr = '0; bus.in_csr_data = '0;
        bus.in_excp = '0; bus.in_excp_code = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] pc, input logic rwe,
                            input logic [4:0] ra, input logic [31:0] rd, input logic cwe,
                            input logic [13:0] ca, input logic [31:0] cd, input logic ex,
                            input logic [6:0] ec);
        bus.in_valid[l] = 1'b1;   bus.in_pc[l] = pc;
        bus.in_reg_we[l] = rwe;   bus.in_reg_addr[l] = ra;  bus.in_reg_data[l] = rd;
        bus.in_csr_we[l] = cwe;   bus.in_csr_addr[l] = ca;  bus.in_csr_data[l] = cd;
        bus.in_excp[l] = ex;      bus.in_excp_code[l] = ec;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.flush = 1'b0; bus.retire_pause = 1'b0;
        clear_lanes();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.flush = 1'b0; bus.retire_pause = 1'b0;
        clear_lanes();
        tick(); tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.out_valid !== 2'b00 || bus.excp_valid !== 1'b0 || bus.out_csr_we !== 1'b0)
            begin errors++; $display("FAIL reset_outputs valid=%b excp=%b csr=%b exp=0", bus.out_valid, bus.excp_valid, bus.out_csr_we); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        set_lane(0, 32'h100, 1, 5'd1, 32'h11, 0, 0, 0, 0, 0);
        set_lane(1, 32'h104, 1, 5'd2, 32'h22, 0, 0, 0, 0, 0);
        tick(); clear_lanes();
        checks++; if (bus.out_valid !== 2'b00 || bus.count !== 4'd2)
            begin errors++; $display("FAIL basic_lat1 valid=%b count=%0d exp 00/2", bus.out_valid, bus.count); end
        tick();
        checks++; if (bus.out_valid !== 2'b11 || bus.out_reg_we !== 2'b11)
            begin errors++; $display("FAIL basic_valid valid=%b we=%b exp 11/11", bus.out_valid, bus.out_reg_we); end
        checks++; if (bus.out_reg_addr[0] !== 5'd1 || bus.out_reg_data[0] !== 32'h11 ||
                      bus.out_reg_addr[1] !== 5'd2 || bus.out_reg_data[1] !== 32'h22)
            begin errors++; $display("FAIL basic_data a0=%0d d0=%h a1=%0d d1=%h exp 1/11 2/22",
                  bus.out_reg_addr[0], bus.out_reg_data[0], bus.out_reg_addr[1], bus.out_reg_data[1]); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL basic_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_two_csr();
        do_reset();
        set_lane(0, 32'h200, 0, 0, 0, 1, 14'h0006, 32'hA, 0, 0);
        set_lane(1, 32'h204, 0, 0, 0, 1, 14'h0030, 32'hB, 0, 0);
        tick(); clear_lanes(); tick();
        checks++; if (bus.out_valid !== 2'b01 || bus.out_csr_we !== 1'b1 || bus.out_csr_addr !== 14'h0006 || bus.out_csr_data !== 32'hA)
            begin errors++; $display("FAIL csr_first valid=%b we=%b addr=%h data=%h exp 01/1/0006/A",
                  bus.out_valid, bus.out_csr_we, bus.out_csr_addr, bus.out_csr_data); end
        tick();
        checks++; if (bus.out_valid !== 2'b01 || bus.out_csr_we !== 1'b1 || bus.out_csr_addr !== 14'h0030 || bus.out_csr_data !== 32'hB)
            begin errors++; $display("FAIL csr_second valid=%b we=%b addr=%h data=%h exp 01/1/0030/B",
                  bus.out_valid, bus.out_csr_we, bus.out_csr_addr, bus.out_csr_data); end
    endtask

    task automatic test_exception();
        do_reset();
        set_lane(0, 32'h1c000004, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        set_lane(1, 32'h1c000008, 1, 5'd4, 32'h44, 0, 0, 0, 1, 7'h0B);
        tick(); clear_lanes();
        set_lane(0, 32'h1c00000c, 1, 5'd5, 32'h55, 0, 0, 0, 0, 0);
        set_lane(1, 32'h1c000010, 1, 5'd6, 32'h66, 0, 0, 0, 0, 0);
        tick(); clear_lanes();
        checks++; if (bus.out_valid !== 2'b01 || bus.out_reg_we !== 2'b01 || bus.out_reg_addr[0] !== 5'd3 || bus.excp_valid !== 1'b0)
            begin errors++; $display("FAIL excp_r3_alone valid=%b we=%b a0=%0d excp=%b exp 01/01/3/0",
                  bus.out_valid, bus.out_reg_we, bus.out_reg_addr[0], bus.excp_valid); end
        tick();
        checks++; if (bus.excp_valid !== 1'b1 || bus.excp_pc !== 32'h1c000008 || bus.excp_code !== 7'h0B)
            begin errors++; $display("FAIL excp_report v=%b pc=%h code=%h exp 1/1c000008/0b",
                  bus.excp_valid, bus.excp_pc, bus.excp_code); end
        checks++; if (bus.out_reg_we !== 2'b00 || bus.count !== 4'd0)
            begin errors++; $display("FAIL excp_squash we=%b count=%0d exp 00/0", bus.out_reg_we, bus.count); end
        tick();
        checks++; if (bus.out_valid !== 2'b00 || bus.excp_valid !== 1'b0 || bus.count !== 4'd0)
            begin errors++; $display("FAIL excp_after valid=%b excp=%b count=%0d exp 00/0/0", bus.out_valid, bus.excp_valid, bus.count); end
    endtask

    task automatic test_full();
        do_reset();
        bus.retire_pause = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clear_lanes();
            set_lane(0, 32'h300 + 32'(c * 8), 1, 5'(2 * c + 1), 32'hF000_0000 + 32'(2 * c), 0, 0, 0, 0, 0);
            set_lane(1, 32'h304 + 32'(c * 8), 1, 5'(2 * c + 2), 32'hF000_0001 + 32'(2 * c), 0, 0, 0, 0, 0);
            tick();
        end
        checks++; if (bus.count !== 4'd8 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL full_state count=%0d ready=%b exp 8/0", bus.count, bus.in_ready); end
        checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL full_paused valid=%b exp=00", bus.out_valid); end
        // release pause while still offering a pair: ready is pre-retire so it is refused
        bus.retire_pause = 1'b0;
        clear_lanes();
        set_lane(0, 32'hDEAD0000, 1, 5'd9, 32'hDEAD, 0, 0, 0, 0, 0);
        set_lane(1, 32'hDEAD0004, 1, 5'd9, 32'hDEAD, 0, 0, 0, 0, 0);
        tick(); clear_lanes();
        checks++; if (bus.count !== 4'd6 || bus.in_ready !== 1'b1 || bus.out_valid !== 2'b11 || bus.out_reg_data[0] !== 32'hF000_0000)
            begin errors++; $display("FAIL full_release count=%0d ready=%b valid=%b d0=%h exp 6/1/11/f0000000",
                  bus.count, bus.in_ready, bus.out_valid, bus.out_reg_data[0]); end
        tick(); tick(); tick();
        checks++; if (bus.count !== 4'd0 || bus.out_valid !== 2'b11 || bus.out_reg_data[1] !== 32'hF000_0007)
            begin errors++; $display("FAIL full_drain count=%0d valid=%b d1=%h exp 0/11/f0000007", bus.count, bus.out_valid, bus.out_reg_data[1]); end
        tick();
        checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL full_no_extra valid=%b exp=00", bus.out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.retire_pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clear_lanes();
            set_lane(0, 32'h400 + 32'(c * 8), 1, 5'd10, 32'(c), 0, 0, 0, 0, 0);
            if (c < 2) set_lane(1, 32'h404 + 32'(c * 8), 1, 5'd11, 32'(c), 0, 0, 0, 0, 0);
            tick();
        end
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre count=%0d exp=5", bus.count); end
        bus.retire_pause = 1'b0; bus.flush = 1'b1;
        clear_lanes();
        set_lane(0, 32'h500, 1, 5'd12, 32'h1, 0, 0, 0, 0, 0);
        set_lane(1, 32'h504, 1, 5'd13, 32'h2, 0, 0, 0, 0, 0);
        tick();
        bus.flush = 1'b0; clear_lanes();
        checks++; if (bus.count !== 4'd0 || bus.out_valid !== 2'b00 || bus.excp_valid !== 1'b0)
            begin errors++; $display("FAIL flush_clear count=%0d valid=%b excp=%b exp 0/00/0", bus.count, bus.out_valid, bus.excp_valid); end
        tick();
        checks++; if (bus.count !== 4'd0 || bus.out_valid !== 2'b00)
            begin errors++; $display("FAIL flush_after count=%0d valid=%b exp 0/00", bus.count, bus.out_valid); end
    endtask

    task automatic test_r0_and_reset();
        do_reset();
        set_lane(0, 32'h600, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0);
        set_lane(1, 32'h604, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
        tick(); clear_lanes(); tick();
        checks++; if (bus.out_valid !== 2'b11 || bus.out_reg_we !== 2'b10 || bus.out_reg_addr[1] !== 5'd7)
            begin errors++; $display("FAIL r0_we valid=%b we=%b a1=%0d exp 11/10/7", bus.out_valid, bus.out_reg_we, bus.out_reg_addr[1]); end
        bus.retire_pause = 1'b1;
        set_lane(0, 32'h700, 1, 5'd8, 32'h88, 1, 14'h10, 32'h1, 0, 0);
        set_lane(1, 32'h704, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        tick(); clear_lanes();
        bus.retire_pause = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 2'b00 || bus.out_csr_we !== 1'b0 || bus.count !== 4'd0)
            begin errors++; $display("FAIL mid_rst_outputs valid=%b csr=%b count=%0d exp 00/0/0", bus.out_valid, bus.out_csr_we, bus.count); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 2'b00 || bus.count !== 4'd0)
            begin errors++; $display("FAIL mid_rst_release ready=%b valid=%b count=%0d exp 1/00/0", bus.in_ready, bus.out_valid, bus.count); end
        tick();
        checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL mid_rst_stale valid=%b exp=00", bus.out_valid); end
    endtask

    // Reference model: a queue of pending instructions, retired by the
    // program-order rules (one CSR per cycle, exceptions only when oldest).
    task automatic test_random();
        commit_entry_t q[$];
        commit_entry_t e;
        logic [RW-1:0] exp_valid, exp_we;
        logic [4:0]    exp_addr [RW];
        logic [31:0]   exp_data [RW];
        logic          exp_csr_we, exp_excp, exp_ready;
        logic [13:0]   exp_csr_addr;
        logic [31:0]   exp_csr_data, exp_pc;
        logic [6:0]    exp_code;
        int            nv, n, k, csrs;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            clear_lanes();
            nv = $urandom_range(0, 2);
            for (int l = 0; l < nv; l++)
                set_lane(l, 32'h2000_0000 + 32'(cyc * 8 + l * 4), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0),
                         14'($urandom_range(0, 16383)), $urandom, ($urandom_range(0, 19) == 0),
                         7'($urandom_range(0, 127)));
            bus.retire_pause = ($urandom_range(0, 2) == 0);
            bus.flush        = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = (DEPTH - q.size()) >= IW;
            checks++; if (bus.in_ready !== exp_ready)
                begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_ready); end

            exp_valid = '0; exp_we = '0; exp_csr_we = 0; exp_excp = 0;
            exp_csr_addr = 0; exp_csr_data = 0; exp_pc = 0; exp_code = 0;
            for (int j = 0; j < RW; j++) begin exp_addr[j] = 0; exp_data[j] = 0; end
            if (bus.flush) begin
                q.delete();
            end else begin
                n = bus.retire_pause ? 0 : ((q.size() < RW) ? q.size() : RW);
                k = 0; csrs = 0;
                for (int j = 0; j < n; j++) begin
                    if (q[j].excp) begin
                        if (j == 0) begin k = 1; exp_excp = 1; exp_pc = q[0].pc; exp_code = q[0].excp_code; end
                        break;
                    end
                    if (q[j].csr_we) begin
                        if (csrs == 1) break;
                        csrs++;
                        exp_csr_we = 1; exp_csr_addr = q[j].csr_addr; exp_csr_data = q[j].csr_data;
                    end
                    k = j + 1;
                end
                for (int j = 0; j < k; j++) begin
                    exp_valid[j] = 1'b1;
                    exp_we[j]    = q[j].reg_we && !q[j].excp && (q[j].reg_addr != 0);
                    exp_addr[j]  = q[j].reg_addr;
                    exp_data[j]  = q[j].reg_data;
                end
                if (exp_excp) q.delete();
                else begin
                    repeat (k) void'(q.pop_front());
                    if (exp_ready && nv > 0)
                        for (int l = 0; l < nv; l++) begin
                            e = '{pc: bus.in_pc[l], reg_we: bus.in_reg_we[l], reg_addr: bus.in_reg_addr[l],
                                  reg_data: bus.in_reg_data[l], csr_we: bus.in_csr_we[l],
                                  csr_addr: bus.in_csr_addr[l], csr_data: bus.in_csr_data[l],
                                  excp: bus.in_excp[l], excp_code: bus.in_excp_code[l]};
                            q.push_back(e);
                        end
                end
            end
            @(posedge clk); #1;

            checks++; if (bus.out_valid !== exp_valid)
                begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_valid); end
            checks++; if (bus.out_reg_we !== exp_we)
                begin errors++; $display("FAIL rnd_reg_we cyc=%0d got=%b exp=%b", cyc, bus.out_reg_we, exp_we); end
            for (int j = 0; j < RW; j++)
                if (exp_we[j]) begin
                    checks++; if (bus.out_reg_addr[j] !== exp_addr[j] || bus.out_reg_data[j] !== exp_data[j])
                        begin errors++; $display("FAIL rnd_reg_lane%0d cyc=%0d got=%0d/%h exp=%0d/%h", j, cyc,
                              bus.out_reg_addr[j], bus.out_reg_data[j], exp_addr[j], exp_data[j]); end
                end
            checks++; if (bus.out_csr_we !== exp_csr_we || (exp_csr_we && (bus.out_csr_addr !== exp_csr_addr || bus.out_csr_data !== exp_csr_data)))
                begin errors++; $display("FAIL rnd_csr cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.out_csr_we,
                      bus.out_csr_addr, bus.out_csr_data, exp_csr_we, exp_csr_addr, exp_csr_data); end
            checks++; if (bus.excp_valid !== exp_excp || (exp_excp && (bus.excp_pc !== exp_pc || bus.excp_code !== exp_code)))
                begin errors++; $display("FAIL rnd_excp cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.excp_valid,
                      bus.excp_pc, bus.excp_code, exp_excp, exp_pc, exp_code); end
            checks++; if (bus.count !== 4'(q.size()))
                begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, q.size()); end
        end
        clear_lanes(); bus.flush = 1'b0; bus.retire_pause = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.retire_pause = 1'b0;
        clear_lanes();
        #1;
        test_reset();
        test_basic();
        test_two_csr();
        test_exception();
        test_full();
        test_flush();
        test_r0_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
